// File: rtl/pipe_ctrl_if.sv
// Hazard/stall scheduler port bundle.
// The slave side is the scheduler; the master side is the surrounding core.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             jump_req_i;
    logic [31:0]      jump_addr_i;
    logic             ex_busy_i;
    logic             ex_is_load_i;
    logic [4:0]       ex_rd_waddr_i;
    logic [4:0]       id_rs1_raddr_i;
    logic [4:0]       id_rs2_raddr_i;
    logic             bus_hold_i;
    logic [1:0]       hold_flag_o;
    logic             jump_flag_o;
    logic [31:0]      jump_addr_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             stall_timeout_o;

    modport master (
        output jump_req_i, jump_addr_i, ex_busy_i, ex_is_load_i,
        output ex_rd_waddr_i, id_rs1_raddr_i, id_rs2_raddr_i, bus_hold_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o,
        input  stall_cnt_o, stall_timeout_o
    );

    modport slave (
        input  jump_req_i, jump_addr_i, ex_busy_i, ex_is_load_i,
        input  ex_rd_waddr_i, id_rs1_raddr_i, id_rs2_raddr_i, bus_hold_i,
        output hold_flag_o, jump_flag_o, jump_addr_o,
        output stall_cnt_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall scheduler: jump flush, ex busy, load-use, bus hold.
// Produces the per-cycle hold code, redirect, stall counter and watchdog.
module pipe_ctrl #(
    parameter int FLUSH_CYC   = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 32
) (
    input logic         clk,
    input logic         rst,
    pipe_ctrl_if.slave  bif
);
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, BUSY} state_e;

    state_e           state_q, state_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             timeout_q, timeout_d;

    logic [1:0]  hold_flag;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        rs1_hit, rs2_hit, load_use;

    assign rs1_hit  = (bif.id_rs1_raddr_i != 5'd0) &&
                      (bif.id_rs1_raddr_i == bif.ex_rd_waddr_i);
    assign rs2_hit  = (bif.id_rs2_raddr_i != 5'd0) &&
                      (bif.id_rs2_raddr_i == bif.ex_rd_waddr_i);
    assign load_use = bif.ex_is_load_i && (bif.ex_rd_waddr_i != 5'd0) &&
                      (rs1_hit || rs2_hit);

    // Next state and hold code, priority jump > flush > busy > load-use > bus.
    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        hold_flag = 2'd0;
        jump_flag = 1'b0;
        jump_addr = 32'd0;
        if (bif.jump_req_i) begin
            jump_flag = 1'b1;
            jump_addr = bif.jump_addr_i;
            hold_flag = 2'd3;
            if (FLUSH_CYC > 1) begin
                state_d = FLUSH;
                flush_d = FW'(FLUSH_CYC - 1);
            end else begin
                state_d = IDLE;
                flush_d = '0;
            end
        end else if (state_q == FLUSH) begin
            hold_flag = 2'd3;
            if (flush_q <= FW'(1)) begin
                state_d = IDLE;
                flush_d = '0;
            end else begin
                flush_d = flush_q - FW'(1);
            end
        end else if (bif.ex_busy_i) begin
            hold_flag = 2'd3;
            state_d   = BUSY;
        end else begin
            state_d = IDLE;
            if (load_use) begin
                hold_flag = 2'd3;
            end else if (bif.bus_hold_i) begin
                hold_flag = 2'd1;
            end
        end
        if (rst) begin
            hold_flag = 2'd0;
            jump_flag = 1'b0;
            jump_addr = 32'd0;
        end
    end

    // Saturating stall counter and consecutive-stall watchdog.
    always_comb begin
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (hold_flag != 2'd0) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (wd_q != WW'(TIMEOUT_CYC)) begin
                wd_d = wd_q + WW'(1);
            end
            if (wd_q >= WW'(TIMEOUT_CYC - 1)) begin
                timeout_d = 1'b1;
            end
        end else begin
            wd_d = '0;
        end
    end

    // State, flush counter, stall counter and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            flush_q   <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bif.hold_flag_o     = hold_flag;
    assign bif.jump_flag_o     = jump_flag;
    assign bif.jump_addr_o     = jump_addr;
    assign bif.stall_cnt_o     = cnt_q;
    assign bif.stall_timeout_o = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances cover FLUSH_CYC=2/TIMEOUT=8
// and FLUSH_CYC=4 with a 3-bit saturating stall counter.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(32)) ifa ();
    pipe_ctrl_if #(.CNT_W(3))  ifb ();

    pipe_ctrl #(.FLUSH_CYC(2), .TIMEOUT_CYC(8), .CNT_W(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .bif (ifa)
    );

    pipe_ctrl #(.FLUSH_CYC(4), .TIMEOUT_CYC(1024), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bif (ifb)
    );

    task automatic idle_inputs();
        ifa.jump_req_i = 0; ifa.jump_addr_i = 0; ifa.ex_busy_i = 0;
        ifa.ex_is_load_i = 0; ifa.ex_rd_waddr_i = 0;
        ifa.id_rs1_raddr_i = 0; ifa.id_rs2_raddr_i = 0; ifa.bus_hold_i = 0;
        ifb.jump_req_i = 0; ifb.jump_addr_i = 0; ifb.ex_busy_i = 0;
        ifb.ex_is_load_i = 0; ifb.ex_rd_waddr_i = 0;
        ifb.id_rs1_raddr_i = 0; ifb.id_rs2_raddr_i = 0; ifb.bus_hold_i = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_total++;
            if (ifa.hold_flag_o !== 2'd0 || ifa.jump_flag_o !== 1'b0 ||
                ifa.stall_cnt_o !== 32'd0)
                $display("FAIL reset_c%0d hold=%0d jf=%0b cnt=%0d want 0/0/0",
                         i, ifa.hold_flag_o, ifa.jump_flag_o, ifa.stall_cnt_o);
            else n_pass++;
        end
        @(negedge clk);
        ifa.jump_req_i = 1; ifa.jump_addr_i = 32'h1234;
        #1;
        n_total++;
        if (ifa.hold_flag_o !== 2'd0 || ifa.jump_flag_o !== 1'b0 ||
            ifa.jump_addr_o !== 32'd0)
            $display("FAIL reset_gate hold=%0d jf=%0b addr=%h want 0/0/0",
                     ifa.hold_flag_o, ifa.jump_flag_o, ifa.jump_addr_o);
        else n_pass++;
        @(negedge clk);
        rst = 0;
        idle_inputs();
        #1;
        n_total++;
        if (ifa.hold_flag_o !== 2'd0 || ifa.stall_cnt_o !== 32'd0 ||
            ifa.stall_timeout_o !== 1'b0)
            $display("FAIL reset_exit hold=%0d cnt=%0d to=%0b want 0/0/0",
                     ifa.hold_flag_o, ifa.stall_cnt_o, ifa.stall_timeout_o);
        else n_pass++;
    endtask

    task automatic test_jump();
        @(negedge clk);
        ifa.jump_req_i = 1; ifa.jump_addr_i = 32'h80;
        #1;
        n_total++;
        if (ifa.jump_flag_o !== 1'b1 || ifa.jump_addr_o !== 32'h80 ||
            ifa.hold_flag_o !== 2'd3)
            $display("FAIL jump_c0 jf=%0b addr=%h hold=%0d want 1/80/3",
                     ifa.jump_flag_o, ifa.jump_addr_o, ifa.hold_flag_o);
        else n_pass++;
        @(negedge clk);
        ifa.jump_req_i = 0; ifa.jump_addr_i = 32'hdead;
        #1;
        n_total++;
        if (ifa.jump_flag_o !== 1'b0 || ifa.jump_addr_o !== 32'h0 ||
            ifa.hold_flag_o !== 2'd3)
            $display("FAIL jump_c1 jf=%0b addr=%h hold=%0d want 0/0/3",
                     ifa.jump_flag_o, ifa.jump_addr_o, ifa.hold_flag_o);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (ifa.hold_flag_o !== 2'd0 || ifa.stall_cnt_o !== 32'd2)
            $display("FAIL jump_c2 hold=%0d cnt=%0d want 0/2",
                     ifa.hold_flag_o, ifa.stall_cnt_o);
        else n_pass++;
    endtask

    task automatic test_load_use();
        logic [4:0] rd_v [4] = '{5'd5, 5'd7, 5'd0, 5'd3};
        logic [4:0] r1_v [4] = '{5'd5, 5'd0, 5'd0, 5'd4};
        logic [4:0] r2_v [4] = '{5'd0, 5'd7, 5'd0, 5'd0};
        logic [1:0] exp  [4] = '{2'd3, 2'd3, 2'd0, 2'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ifa.ex_is_load_i = 1;
            ifa.ex_rd_waddr_i = rd_v[i];
            ifa.id_rs1_raddr_i = r1_v[i];
            ifa.id_rs2_raddr_i = r2_v[i];
            #1;
            n_total++;
            if (ifa.hold_flag_o !== exp[i])
                $display("FAIL load_use_%0d hold=%0d want %0d",
                         i, ifa.hold_flag_o, exp[i]);
            else n_pass++;
            @(negedge clk);
            idle_inputs();
            #1;
            n_total++;
            if (ifa.hold_flag_o !== 2'd0)
                $display("FAIL load_use_after_%0d hold=%0d want 0",
                         i, ifa.hold_flag_o);
            else n_pass++;
        end
        n_total++;
        if (ifa.stall_cnt_o !== 32'd4)
            $display("FAIL load_use_cnt cnt=%0d want 4", ifa.stall_cnt_o);
        else n_pass++;
    endtask

    task automatic test_busy();
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                ifa.bus_hold_i = 1;
                ifa.ex_busy_i = (c < 4);
                ifa.jump_req_i = (v == 1 && c == 2);
                ifa.jump_addr_i = (v == 1 && c == 2) ? 32'h200 : 32'h0;
                #1;
                n_total++;
                if (c == 4) begin
                    if (ifa.hold_flag_o !== 2'd1 || ifa.jump_flag_o !== 1'b0)
                        $display("FAIL busy_v%0d_end hold=%0d jf=%0b want 1/0",
                                 v, ifa.hold_flag_o, ifa.jump_flag_o);
                    else n_pass++;
                end else if (v == 1 && c == 2) begin
                    if (ifa.hold_flag_o !== 2'd3 || ifa.jump_flag_o !== 1'b1 ||
                        ifa.jump_addr_o !== 32'h200)
                        $display("FAIL busy_jump hold=%0d jf=%0b addr=%h want 3/1/200",
                                 ifa.hold_flag_o, ifa.jump_flag_o, ifa.jump_addr_o);
                    else n_pass++;
                end else begin
                    if (ifa.hold_flag_o !== 2'd3 || ifa.jump_flag_o !== 1'b0)
                        $display("FAIL busy_v%0d_c%0d hold=%0d jf=%0b want 3/0",
                                 v, c, ifa.hold_flag_o, ifa.jump_flag_o);
                    else n_pass++;
                end
            end
            @(negedge clk);
            idle_inputs();
            #1;
            n_total++;
            if (ifa.hold_flag_o !== 2'd0)
                $display("FAIL busy_v%0d_idle hold=%0d want 0", v, ifa.hold_flag_o);
            else n_pass++;
        end
        n_total++;
        if (ifa.stall_cnt_o !== 32'd14 || ifa.stall_timeout_o !== 1'b0)
            $display("FAIL busy_cnt cnt=%0d to=%0b want 14/0",
                     ifa.stall_cnt_o, ifa.stall_timeout_o);
        else n_pass++;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ifa.bus_hold_i = 1;
            #1;
            if (i == 7) begin
                n_total++;
                if (ifa.stall_timeout_o !== 1'b0)
                    $display("FAIL timeout_early to=%0b want 0", ifa.stall_timeout_o);
                else n_pass++;
            end
        end
        @(negedge clk);
        ifa.bus_hold_i = 0;
        #1;
        n_total++;
        if (ifa.stall_timeout_o !== 1'b1 || ifa.stall_cnt_o !== 32'd22)
            $display("FAIL timeout_set to=%0b cnt=%0d want 1/22",
                     ifa.stall_timeout_o, ifa.stall_cnt_o);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (ifa.stall_timeout_o !== 1'b1)
            $display("FAIL timeout_sticky to=%0b want 1", ifa.stall_timeout_o);
        else n_pass++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ifb.bus_hold_i = 1;
            #1;
            if (i == 7) begin
                n_total++;
                if (ifb.stall_cnt_o !== 3'd7)
                    $display("FAIL sat_reach cnt=%0d want 7", ifb.stall_cnt_o);
                else n_pass++;
            end
        end
        @(negedge clk);
        ifb.bus_hold_i = 0;
        #1;
        n_total++;
        if (ifb.stall_cnt_o !== 3'd7)
            $display("FAIL sat_hold cnt=%0d want 7", ifb.stall_cnt_o);
        else n_pass++;
    endtask

    task automatic test_flush_reset();
        @(negedge clk);
        ifb.jump_req_i = 1; ifb.jump_addr_i = 32'h44;
        #1;
        n_total++;
        if (ifb.jump_flag_o !== 1'b1 || ifb.jump_addr_o !== 32'h44)
            $display("FAIL fr_jump jf=%0b addr=%h want 1/44",
                     ifb.jump_flag_o, ifb.jump_addr_o);
        else n_pass++;
        @(negedge clk);
        ifb.jump_req_i = 0; ifb.jump_addr_i = 0;
        #1;
        n_total++;
        if (ifb.hold_flag_o !== 2'd3)
            $display("FAIL fr_flush hold=%0d want 3", ifb.hold_flag_o);
        else n_pass++;
        @(negedge clk);
        rst = 1;
        #1;
        n_total++;
        if (ifb.hold_flag_o !== 2'd0)
            $display("FAIL fr_in_rst hold=%0d want 0", ifb.hold_flag_o);
        else n_pass++;
        @(negedge clk);
        rst = 0;
        #1;
        n_total++;
        if (ifb.hold_flag_o !== 2'd0 || ifb.stall_cnt_o !== 3'd0 ||
            ifa.stall_timeout_o !== 1'b0)
            $display("FAIL fr_after hold=%0d cnt=%0d to_a=%0b want 0/0/0",
                     ifb.hold_flag_o, ifb.stall_cnt_o, ifa.stall_timeout_o);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (ifb.hold_flag_o !== 2'd0 || ifb.stall_cnt_o !== 3'd0)
            $display("FAIL fr_residual hold=%0d cnt=%0d want 0/0",
                     ifb.hold_flag_o, ifb.stall_cnt_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_jump();
        test_load_use();
        test_busy();
        test_timeout();
        test_saturate();
        test_flush_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
